// File: rtl/decode_stage_if.sv
// Decode-stage bundle: fetch instruction/redirect, writeback port, hazard controls
// and the registered ID/EX outputs. master = surrounding pipeline, slave = decode stage.
interface decode_stage_if #(
  parameter int XLEN = 32
);
  logic [31:0]     InstrD;
  logic [XLEN-1:0] PCD;
  logic [XLEN-1:0] PCPlus4D;
  logic            StallE;
  logic            FlushE;
  logic            RegWriteW;
  logic [4:0]      RdW;
  logic [XLEN-1:0] ResultW;

  logic            PCSrcD;
  logic            JalD;
  logic [XLEN-1:0] PCTargetD;

  logic [XLEN-1:0] RD1E;
  logic [XLEN-1:0] RD2E;
  logic [XLEN-1:0] ImmExtE;
  logic [4:0]      Rs1E;
  logic [4:0]      Rs2E;
  logic [4:0]      RdE;
  logic [XLEN-1:0] PCE;
  logic [XLEN-1:0] PCPlus4E;
  logic            RegWriteE;
  logic            MemWriteE;
  logic            ALUSrcE;
  logic [1:0]      ResultSrcE;
  logic [3:0]      ALUControlE;

  modport master (
    output InstrD, PCD, PCPlus4D, StallE, FlushE, RegWriteW, RdW, ResultW,
    input  PCSrcD, JalD, PCTargetD,
    input  RD1E, RD2E, ImmExtE, Rs1E, Rs2E, RdE, PCE, PCPlus4E,
    input  RegWriteE, MemWriteE, ALUSrcE, ResultSrcE, ALUControlE
  );

  modport slave (
    input  InstrD, PCD, PCPlus4D, StallE, FlushE, RegWriteW, RdW, ResultW,
    output PCSrcD, JalD, PCTargetD,
    output RD1E, RD2E, ImmExtE, Rs1E, Rs2E, RdE, PCE, PCPlus4E,
    output RegWriteE, MemWriteE, ALUSrcE, ResultSrcE, ALUControlE
  );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode: register file, immediates, control decode, zero-cycle branch/jump resolve.
// One cycle to the ID/EX outputs; FlushE loads a bubble, StallE holds, FlushE wins.
module decode_stage #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input logic           clk,
  input logic           rst,
  decode_stage_if.slave dec_if
);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  localparam logic [3:0] ALU_ADD   = 4'h0;
  localparam logic [3:0] ALU_SUB   = 4'h1;
  localparam logic [3:0] ALU_AND   = 4'h2;
  localparam logic [3:0] ALU_OR    = 4'h3;
  localparam logic [3:0] ALU_XOR   = 4'h4;
  localparam logic [3:0] ALU_SLL   = 4'h5;
  localparam logic [3:0] ALU_SRL   = 4'h6;
  localparam logic [3:0] ALU_SRA   = 4'h7;
  localparam logic [3:0] ALU_SLT   = 4'h8;
  localparam logic [3:0] ALU_SLTU  = 4'h9;
  localparam logic [3:0] ALU_PASSB = 4'hA;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  typedef struct packed {
    logic            regwrite;
    logic            memwrite;
    logic            alusrc;
    logic [1:0]      resultsrc;
    logic [3:0]      aluctl;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pcplus4;
  } idex_t;

  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rs1_a;
  logic [4:0]  rs2_a;
  logic [4:0]  rd_a;

  assign instr  = dec_if.InstrD;
  assign opcode = instr[6:0];
  assign rd_a   = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1_a  = instr[19:15];
  assign rs2_a  = instr[24:20];
  assign funct7 = instr[31:25];

  // Register file: x0 is never written, and reads of it are forced to zero.
  logic [XLEN-1:0] rf_q [NREGS];
  logic            wb_en;

  assign wb_en = dec_if.RegWriteW && (dec_if.RdW != 5'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        rf_q[i] <= '0;
      end
    end else if (wb_en) begin
      rf_q[dec_if.RdW] <= dec_if.ResultW;
    end
  end

  // Write-first bypass so a same-cycle writeback is visible to compare and ID/EX.
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;

  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (rs1_a != 5'd0) begin
      rs1_val = (wb_en && (dec_if.RdW == rs1_a)) ? dec_if.ResultW : rf_q[rs1_a];
    end
    if (rs2_a != 5'd0) begin
      rs2_val = (wb_en && (dec_if.RdW == rs2_a)) ? dec_if.ResultW : rf_q[rs2_a];
    end
  end

  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_j;
  logic [XLEN-1:0] imm_u;

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};

  logic            legal;
  logic            is_br;
  logic            is_jal;
  logic            is_jalr;
  logic            use_rs1;
  logic            use_rs2;
  logic            regwrite;
  logic            memwrite;
  logic            alusrc;
  logic [1:0]      resultsrc;
  logic [3:0]      aluctl;
  logic [XLEN-1:0] imm;

  always_comb begin
    legal     = 1'b0;
    is_br     = 1'b0;
    is_jal    = 1'b0;
    is_jalr   = 1'b0;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    regwrite  = 1'b0;
    memwrite  = 1'b0;
    alusrc    = 1'b0;
    resultsrc = RES_ALU;
    aluctl    = ALU_ADD;
    imm       = '0;
    case (opcode)
      OP_R: begin
        legal    = 1'b1;
        use_rs1  = 1'b1;
        use_rs2  = 1'b1;
        regwrite = 1'b1;
        case ({funct7, funct3})
          {7'h00, 3'b000}: aluctl = ALU_ADD;
          {7'h20, 3'b000}: aluctl = ALU_SUB;
          {7'h00, 3'b001}: aluctl = ALU_SLL;
          {7'h00, 3'b010}: aluctl = ALU_SLT;
          {7'h00, 3'b011}: aluctl = ALU_SLTU;
          {7'h00, 3'b100}: aluctl = ALU_XOR;
          {7'h00, 3'b101}: aluctl = ALU_SRL;
          {7'h20, 3'b101}: aluctl = ALU_SRA;
          {7'h00, 3'b110}: aluctl = ALU_OR;
          {7'h00, 3'b111}: aluctl = ALU_AND;
          default:         legal  = 1'b0;
        endcase
      end
      OP_I: begin
        legal    = 1'b1;
        use_rs1  = 1'b1;
        regwrite = 1'b1;
        alusrc   = 1'b1;
        imm      = imm_i;
        case (funct3)
          3'b000: aluctl = ALU_ADD;
          3'b010: aluctl = ALU_SLT;
          3'b011: aluctl = ALU_SLTU;
          3'b100: aluctl = ALU_XOR;
          3'b110: aluctl = ALU_OR;
          3'b111: aluctl = ALU_AND;
          3'b001: begin
            aluctl = ALU_SLL;
            legal  = (funct7 == 7'h00);
          end
          3'b101: begin
            aluctl = (funct7 == 7'h20) ? ALU_SRA : ALU_SRL;
            legal  = (funct7 == 7'h00) || (funct7 == 7'h20);
          end
          default: legal = 1'b0;
        endcase
      end
      OP_LW: begin
        legal     = (funct3 == 3'b010);
        use_rs1   = 1'b1;
        regwrite  = 1'b1;
        alusrc    = 1'b1;
        resultsrc = RES_MEM;
        imm       = imm_i;
      end
      OP_SW: begin
        legal    = (funct3 == 3'b010);
        use_rs1  = 1'b1;
        use_rs2  = 1'b1;
        memwrite = 1'b1;
        alusrc   = 1'b1;
        imm      = imm_s;
      end
      OP_BR: begin
        legal   = (funct3 != 3'b010) && (funct3 != 3'b011);
        is_br   = legal;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        imm     = imm_b;
      end
      OP_JAL: begin
        legal     = 1'b1;
        is_jal    = 1'b1;
        regwrite  = 1'b1;
        resultsrc = RES_PC4;
        imm       = imm_j;
      end
      OP_JALR: begin
        legal     = (funct3 == 3'b000);
        is_jalr   = legal;
        use_rs1   = 1'b1;
        regwrite  = 1'b1;
        alusrc    = 1'b1;
        resultsrc = RES_PC4;
        imm       = imm_i;
      end
      OP_LUI: begin
        legal    = 1'b1;
        regwrite = 1'b1;
        alusrc   = 1'b1;
        aluctl   = ALU_PASSB;
        imm      = imm_u;
      end
      default: legal = 1'b0;
    endcase
  end

  logic br_taken;

  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'b000:  br_taken = (rs1_val == rs2_val);
      3'b001:  br_taken = (rs1_val != rs2_val);
      3'b100:  br_taken = ($signed(rs1_val) <  $signed(rs2_val));
      3'b101:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
      3'b110:  br_taken = (rs1_val <  rs2_val);
      3'b111:  br_taken = (rs1_val >= rs2_val);
      default: br_taken = 1'b0;
    endcase
  end

  logic [XLEN-1:0] tgt_b;
  logic [XLEN-1:0] tgt_j;
  logic [XLEN-1:0] jalr_sum;

  assign tgt_b    = dec_if.PCD + imm_b;
  assign tgt_j    = dec_if.PCD + imm_j;
  assign jalr_sum = rs1_val + imm_i;

  // Non-redirecting instructions still present PCD+ImmB so the output never floats.
  assign dec_if.PCSrcD    = (is_br && br_taken) || is_jalr;
  assign dec_if.JalD      = is_jal;
  assign dec_if.PCTargetD = is_jal  ? tgt_j :
                            is_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : tgt_b;

  idex_t idex_d;
  idex_t idex_q;

  // Illegal encodings load the same all-zero bubble as a flush.
  always_comb begin
    idex_d = '0;
    if (legal) begin
      idex_d.regwrite  = regwrite;
      idex_d.memwrite  = memwrite;
      idex_d.alusrc    = alusrc;
      idex_d.resultsrc = resultsrc;
      idex_d.aluctl    = aluctl;
      idex_d.rd1       = use_rs1 ? rs1_val : '0;
      idex_d.rd2       = use_rs2 ? rs2_val : '0;
      idex_d.imm       = imm;
      idex_d.rs1       = use_rs1 ? rs1_a : 5'd0;
      idex_d.rs2       = use_rs2 ? rs2_a : 5'd0;
      idex_d.rd        = regwrite ? rd_a : 5'd0;
      idex_d.pc        = dec_if.PCD;
      idex_d.pcplus4   = dec_if.PCPlus4D;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idex_q <= '0;
    end else if (dec_if.FlushE) begin
      idex_q <= '0;
    end else if (!dec_if.StallE) begin
      idex_q <= idex_d;
    end
  end

  assign dec_if.RegWriteE   = idex_q.regwrite;
  assign dec_if.MemWriteE   = idex_q.memwrite;
  assign dec_if.ALUSrcE     = idex_q.alusrc;
  assign dec_if.ResultSrcE  = idex_q.resultsrc;
  assign dec_if.ALUControlE = idex_q.aluctl;
  assign dec_if.RD1E        = idex_q.rd1;
  assign dec_if.RD2E        = idex_q.rd2;
  assign dec_if.ImmExtE     = idex_q.imm;
  assign dec_if.Rs1E        = idex_q.rs1;
  assign dec_if.Rs2E        = idex_q.rs2;
  assign dec_if.RdE         = idex_q.rd;
  assign dec_if.PCE         = idex_q.pc;
  assign dec_if.PCPlus4E    = idex_q.pcplus4;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: vector table for single-instruction decode plus
// hand sequences for reset, writeback bypass and ID/EX stall/flush.
module tb_decode_stage;

  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam int NV = 25;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decode_stage_if #(.XLEN(32)) dif ();
  decode_stage #(.XLEN(32), .NREGS(32)) dut (.clk(clk), .rst(rst), .dec_if(dif));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        legal;
    logic        pcsrc;
    logic        jal;
    logic        chk_tgt;
    logic [31:0] tgt;
    logic        regw;
    logic        memw;
    logic        alusrc;
    logic [1:0]  rsrc;
    logic [3:0]  alu;
    logic [31:0] imm;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } vec_t;

  vec_t vecs [NV];

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [11:0] imm,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd);
    return {imm, rd, 7'b0110111};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_write(input logic [4:0] r, input logic [31:0] v);
    dif.RegWriteW = 1'b1;
    dif.RdW       = r;
    dif.ResultW   = v;
    tick();
    dif.RegWriteW = 1'b0;
    dif.RdW       = 5'd0;
  endtask

  function automatic logic e_any();
    return |{dif.RD1E, dif.RD2E, dif.ImmExtE, dif.Rs1E, dif.Rs2E, dif.RdE, dif.PCE,
             dif.PCPlus4E, dif.RegWriteE, dif.MemWriteE, dif.ALUSrcE, dif.ResultSrcE,
             dif.ALUControlE};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // fields: instr, pc, legal, pcsrc, jal, chk_tgt, tgt, regw, memw, alusrc, rsrc, alu, imm, rd1, rd2, rs1, rs2, rd
    // register state: x1=7 x2=7 x3=8 x4=-1 x5=1 x6=0x203
    vecs[0]  = '{enc_r(7'h00, 5'd3, 5'd1, 3'd0, 5'd7), 32'h10, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 2'b00, 4'h0, 32'h0, 32'h7, 32'h8, 5'd1, 5'd3, 5'd7};
    vecs[1]  = '{enc_r(7'h20, 5'd5, 5'd4, 3'd0, 5'd8), 32'h14, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 2'b00, 4'h1, 32'h0, 32'hFFFFFFFF, 32'h1, 5'd4, 5'd5, 5'd8};
    vecs[2]  = '{enc_r(7'h20, 5'd5, 5'd4, 3'd5, 5'd9), 32'h18, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 2'b00, 4'h7, 32'h0, 32'hFFFFFFFF, 32'h1, 5'd4, 5'd5, 5'd9};
    vecs[3]  = '{enc_r(7'h00, 5'd5, 5'd4, 3'd3, 5'd9), 32'h1C, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 2'b00, 4'h9, 32'h0, 32'hFFFFFFFF, 32'h1, 5'd4, 5'd5, 5'd9};
    vecs[4]  = '{enc_i(OP_I, 12'hFFD, 5'd1, 3'd0, 5'd10), 32'h20, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 2'b00, 4'h0, 32'hFFFFFFFD, 32'h7, 32'h0, 5'd1, 5'd0, 5'd10};
    vecs[5]  = '{enc_i(OP_I, 12'h7FF, 5'd3, 3'd4, 5'd10), 32'h24, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 2'b00, 4'h4, 32'h7FF, 32'h8, 32'h0, 5'd3, 5'd0, 5'd10};
    vecs[6]  = '{enc_i(OP_I, 12'h404, 5'd4, 3'd5, 5'd11), 32'h28, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 2'b00, 4'h7, 32'h404, 32'hFFFFFFFF, 32'h0, 5'd4, 5'd0, 5'd11};
    vecs[7]  = '{enc_i(OP_LW, 12'hFFC, 5'd6, 3'd2, 5'd12), 32'h2C, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 2'b01, 4'h0, 32'hFFFFFFFC, 32'h203, 32'h0, 5'd6, 5'd0, 5'd12};
    vecs[8]  = '{enc_s(12'h008, 5'd3, 5'd1, 3'd2), 32'h30, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 2'b00, 4'h0, 32'h8, 32'h7, 32'h8, 5'd1, 5'd3, 5'd0};
    vecs[9]  = '{enc_u(20'hABCDE, 5'd13), 32'h34, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 2'b00, 4'hA, 32'hABCDE000, 32'h0, 32'h0, 5'd0, 5'd0, 5'd13};
    vecs[10] = '{enc_b(13'h0010, 5'd2, 5'd1, 3'd0), 32'h40, 1'b1, 1'b1, 1'b0, 1'b1, 32'h50, 1'b0, 1'b0, 1'b0, 2'b00, 4'h0, 32'h10, 32'h7, 32'h7, 5'd1, 5'd2, 5'd0};
    vecs[11] = '{enc_b(13'h0010, 5'd3, 5'd1, 3'd0), 32'h40, 1'b1, 1'b0, 1'b0, 1'b1, 32'h50, 1'b0, 1'b0, 1'b0, 2'b00, 4'h0, 32'h10, 32'h7, 32'h8, 5'd1, 5'd3, 5'd0};
    vecs[12] = '{enc_b(13'h1FF8, 5'd5, 5'd4, 3'd4), 32'h80, 1'b1, 1'b1, 1'b0, 1'b1, 32'h78, 1'b0, 1'b0, 1'b0, 2'b00, 4'h0, 32'hFFFFFFF8, 32'hFFFFFFFF, 32'h1, 5'd4, 5'd5, 5'd0};
    vecs[13] = '{enc_b(13'h1FF8, 5'd5, 5'd4, 3'd6), 32'h80, 1'b1, 1'b0, 1'b0, 1'b1, 32'h78, 1'b0, 1'b0, 1'b0, 2'b00, 4'h0, 32'hFFFFFFF8, 32'hFFFFFFFF, 32'h1, 5'd4, 5'd5, 5'd0};
    vecs[14] = '{enc_b(13'h000C, 5'd5, 5'd4, 3'd5), 32'h80, 1'b1, 1'b0, 1'b0, 1'b1, 32'h8C, 1'b0, 1'b0, 1'b0, 2'b00, 4'h0, 32'hC, 32'hFFFFFFFF, 32'h1, 5'd4, 5'd5, 5'd0};
    vecs[15] = '{enc_b(13'h000C, 5'd5, 5'd4, 3'd7), 32'h80, 1'b1, 1'b1, 1'b0, 1'b1, 32'h8C, 1'b0, 1'b0, 1'b0, 2'b00, 4'h0, 32'hC, 32'hFFFFFFFF, 32'h1, 5'd4, 5'd5, 5'd0};
    vecs[16] = '{enc_b(13'h0004, 5'd3, 5'd1, 3'd1), 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h4, 1'b0, 1'b0, 1'b0, 2'b00, 4'h0, 32'h4, 32'h7, 32'h8, 5'd1, 5'd3, 5'd0};
    vecs[17] = '{enc_j(21'h000020, 5'd1), 32'h100, 1'b1, 1'b0, 1'b1, 1'b1, 32'h120, 1'b1, 1'b0, 1'b0, 2'b10, 4'h0, 32'h20, 32'h0, 32'h0, 5'd0, 5'd0, 5'd1};
    vecs[18] = '{enc_j(21'h000020, 5'd2), 32'hFFFFFFF0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 1'b0, 1'b0, 2'b10, 4'h0, 32'h20, 32'h0, 32'h0, 5'd0, 5'd0, 5'd2};
    vecs[19] = '{enc_i(OP_JALR, 12'h000, 5'd6, 3'd0, 5'd1), 32'h100, 1'b1, 1'b1, 1'b0, 1'b1, 32'h202, 1'b1, 1'b0, 1'b1, 2'b10, 4'h0, 32'h0, 32'h203, 32'h0, 5'd6, 5'd0, 5'd1};
    vecs[20] = '{enc_i(OP_JALR, 12'h004, 5'd4, 3'd0, 5'd5), 32'h104, 1'b1, 1'b1, 1'b0, 1'b1, 32'h2, 1'b1, 1'b0, 1'b1, 2'b10, 4'h0, 32'h4, 32'hFFFFFFFF, 32'h0, 5'd4, 5'd0, 5'd5};
    vecs[21] = '{32'h0000007F, 32'h200, 1'b0, 1'b0, 1'b0, 1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 2'b00, 4'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0};
    vecs[22] = '{enc_r(7'h01, 5'd3, 5'd1, 3'd0, 5'd7), 32'h204, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2'b00, 4'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0};
    vecs[23] = '{enc_i(OP_LW, 12'h004, 5'd1, 3'd0, 5'd12), 32'h208, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2'b00, 4'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0};
    vecs[24] = '{enc_b(13'h0010, 5'd2, 5'd1, 3'd2), 32'h40, 1'b0, 1'b0, 1'b0, 1'b1, 32'h50, 1'b0, 1'b0, 1'b0, 2'b00, 4'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0};

    rst           = 1'b1;
    dif.InstrD    = enc_i(OP_I, 12'd5, 5'd0, 3'd0, 5'd1);
    dif.PCD       = 32'h0;
    dif.PCPlus4D  = 32'h4;
    dif.StallE    = 1'b0;
    dif.FlushE    = 1'b0;
    dif.RegWriteW = 1'b0;
    dif.RdW       = 5'd0;
    dif.ResultW   = 32'h0;

    // Reset holds the bubble even across an edge; redirects still follow InstrD.
    #1;
    chk("rst_e_zero", {31'b0, e_any()}, 32'h0);
    chk("rst_pcsrc", {31'b0, dif.PCSrcD}, 32'h0);
    tick();
    chk("rst_e_zero_edge", {31'b0, e_any()}, 32'h0);
    rst = 1'b0;
    tick();
    chk("rel_regwrite", {31'b0, dif.RegWriteE}, 32'h1);
    chk("rel_imm", dif.ImmExtE, 32'h5);
    chk("rel_rd", {27'b0, dif.RdE}, 32'h1);
    chk("rel_alu", {28'b0, dif.ALUControlE}, 32'h0);
    chk("rel_alusrc", {31'b0, dif.ALUSrcE}, 32'h1);

    // Writeback bypass, and x0 neither bypassed nor written.
    dif.RegWriteW = 1'b1;
    dif.RdW       = 5'd3;
    dif.ResultW   = 32'h1234;
    dif.InstrD    = enc_r(7'h00, 5'd0, 5'd3, 3'd0, 5'd4);
    tick();
    chk("byp_rd1", dif.RD1E, 32'h1234);
    dif.RdW     = 5'd0;
    dif.ResultW = 32'hFFFF;
    dif.InstrD  = enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd5);
    tick();
    chk("x0_byp_rd1", dif.RD1E, 32'h0);
    dif.RegWriteW = 1'b0;
    tick();
    chk("x0_read_rd1", dif.RD1E, 32'h0);
    dif.InstrD = enc_r(7'h00, 5'd0, 5'd3, 3'd0, 5'd5);
    tick();
    chk("x3_stored_rd1", dif.RD1E, 32'h1234);

    // Mid-operation reset clears ID/EX and the register file without an edge.
    wb_write(5'd1, 32'h55);
    dif.InstrD = enc_r(7'h00, 5'd0, 5'd1, 3'd0, 5'd2);
    tick();
    chk("pre_rst_rd1", dif.RD1E, 32'h55);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_e_zero", {31'b0, e_any()}, 32'h0);
    rst = 1'b0;
    tick();
    chk("post_rst_regwrite", {31'b0, dif.RegWriteE}, 32'h1);
    chk("post_rst_x1", dif.RD1E, 32'h0);

    wb_write(5'd1, 32'h7);
    wb_write(5'd2, 32'h7);
    wb_write(5'd3, 32'h8);
    wb_write(5'd4, 32'hFFFFFFFF);
    wb_write(5'd5, 32'h1);
    wb_write(5'd6, 32'h203);

    // Branch compare must see the same-cycle writeback value.
    dif.InstrD    = enc_b(13'h0010, 5'd2, 5'd1, 3'd0);
    dif.PCD       = 32'h40;
    dif.RegWriteW = 1'b1;
    dif.RdW       = 5'd2;
    dif.ResultW   = 32'h9;
    #1;
    chk("beq_byp_pcsrc", {31'b0, dif.PCSrcD}, 32'h0);
    dif.RegWriteW = 1'b0;
    dif.RdW       = 5'd0;
    #1;
    chk("beq_nobyp_pcsrc", {31'b0, dif.PCSrcD}, 32'h1);

    for (int i = 0; i < NV; i++) begin
      dif.InstrD   = vecs[i].instr;
      dif.PCD      = vecs[i].pc;
      dif.PCPlus4D = vecs[i].pc + 32'd4;
      #1;
      chk($sformatf("v%0d_pcsrc", i), {31'b0, dif.PCSrcD}, {31'b0, vecs[i].pcsrc});
      chk($sformatf("v%0d_jal", i), {31'b0, dif.JalD}, {31'b0, vecs[i].jal});
      if (vecs[i].chk_tgt) begin
        chk($sformatf("v%0d_target", i), dif.PCTargetD, vecs[i].tgt);
      end
      tick();
      chk($sformatf("v%0d_regwrite", i), {31'b0, dif.RegWriteE}, {31'b0, vecs[i].regw});
      chk($sformatf("v%0d_memwrite", i), {31'b0, dif.MemWriteE}, {31'b0, vecs[i].memw});
      chk($sformatf("v%0d_alusrc", i), {31'b0, dif.ALUSrcE}, {31'b0, vecs[i].alusrc});
      chk($sformatf("v%0d_resultsrc", i), {30'b0, dif.ResultSrcE}, {30'b0, vecs[i].rsrc});
      chk($sformatf("v%0d_aluctl", i), {28'b0, dif.ALUControlE}, {28'b0, vecs[i].alu});
      chk($sformatf("v%0d_imm", i), dif.ImmExtE, vecs[i].imm);
      chk($sformatf("v%0d_rd1", i), dif.RD1E, vecs[i].rd1);
      chk($sformatf("v%0d_rd2", i), dif.RD2E, vecs[i].rd2);
      chk($sformatf("v%0d_rs1", i), {27'b0, dif.Rs1E}, {27'b0, vecs[i].rs1});
      chk($sformatf("v%0d_rs2", i), {27'b0, dif.Rs2E}, {27'b0, vecs[i].rs2});
      chk($sformatf("v%0d_rd", i), {27'b0, dif.RdE}, {27'b0, vecs[i].rd});
      chk($sformatf("v%0d_pce", i), dif.PCE, vecs[i].legal ? vecs[i].pc : 32'h0);
      chk($sformatf("v%0d_pcplus4e", i), dif.PCPlus4E,
          vecs[i].legal ? vecs[i].pc + 32'd4 : 32'h0);
    end

    // Stall holds for two edges; flush beats stall; then normal loading resumes.
    dif.InstrD   = enc_r(7'h00, 5'd3, 5'd1, 3'd0, 5'd7);
    dif.PCD      = 32'h300;
    dif.PCPlus4D = 32'h304;
    tick();
    chk("stl_load_rd1", dif.RD1E, 32'h7);
    dif.StallE   = 1'b1;
    dif.InstrD   = enc_r(7'h20, 5'd5, 5'd4, 3'd0, 5'd8);
    dif.PCD      = 32'h304;
    dif.PCPlus4D = 32'h308;
    tick();
    tick();
    chk("stl_hold_rd1", dif.RD1E, 32'h7);
    chk("stl_hold_rd2", dif.RD2E, 32'h8);
    chk("stl_hold_rd", {27'b0, dif.RdE}, 32'h7);
    chk("stl_hold_alu", {28'b0, dif.ALUControlE}, 32'h0);
    chk("stl_hold_pce", dif.PCE, 32'h300);
    dif.FlushE = 1'b1;
    tick();
    chk("flush_over_stall", {31'b0, e_any()}, 32'h0);
    dif.FlushE = 1'b0;
    dif.StallE = 1'b0;
    tick();
    chk("resume_alu", {28'b0, dif.ALUControlE}, 32'h1);
    chk("resume_rd", {27'b0, dif.RdE}, 32'h8);
    chk("resume_pce", dif.PCE, 32'h304);
    dif.FlushE = 1'b1;
    tick();
    chk("flush_only", {31'b0, e_any()}, 32'h0);
    dif.FlushE = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
